ram_bist_seq: RTL

- Self-checking sequencer that drives the single-port 32x8 block RAM and consumes its read data.
- On a start pulse it makes one pass:
  - writes a seeded pattern to every address;
  - reads every address back;
  - compares each word against the expected value, accounting for RAM read latency.
- Reports busy/done/pass, an error count and the first failing address.
- Sits directly upstream of the RAM IP instance in the top level and occupies the controller slot.

---
 rtl/ram_bist_seq_if.sv | 41 ++++
 rtl/ram_bist_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_seq_if.sv
// ---------------------------------------------------------------------------
// ram_bist_seq_if
// Bus between the BIST sequencer and the single-port block RAM.
//
// Signals:
//   ram_en      - RAM enable, driven by the sequencer
//   ram_we      - write enable (1 = write, 0 = read)
//   ram_addr    - word address, ADDR_W bits
//   ram_wr_data - write data, DATA_W bits
//   ram_rd_data - read data returned by the RAM, DATA_W bits
//
// Modports:
//   master - the sequencer side (drives en/we/addr/wr_data)
//   slave  - the RAM side (drives rd_data)
// ---------------------------------------------------------------------------
interface ram_bist_seq_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    modport master (
        output ram_en,
        output ram_we,
        output ram_addr,
        output ram_wr_data,
        input  ram_rd_data
    );

    modport slave (
        input  ram_en,
        input  ram_we,
        input  ram_addr,
        input  ram_wr_data,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_bist_seq.sv
// ---------------------------------------------------------------------------
// ram_bist_seq
// Self-checking sequencer for a single-port RAM. On a start request it writes
// (addr + seed) to every word, reads every word back and compares the read
// data against the same pattern, allowing RD_LAT cycles of read latency. The
// seed advances by one after each pass so consecutive passes use different
// data.
//
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - asynchronous active-low reset
//   start          - pass request, only looked at while idle
//   ram            - RAM bus (ram_bist_seq_if.master)
//   busy           - high while writing, reading or draining
//   done           - one-cycle pulse at the end of a pass
//   pass           - result of the last completed pass, held until next start
//   err_cnt        - mismatch count of the current/last pass, saturates at 255
//   first_err_addr - address of the first mismatch of the current/last pass
//
// Build option:
//   BIST_AUTO_LOOP_EN - when defined, DONE restarts the next pass directly so
//                       passes repeat until reset.
// ---------------------------------------------------------------------------
module ram_bist_seq #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    ram_bist_seq_if.master    ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_cnt;
    logic [2:0]        r_drainCnt;
    logic [DATA_W-1:0] r_seed;
    logic [7:0]        r_errCnt;
    logic [ADDR_W-1:0] r_firstErr;
    logic              r_pass;
    logic              r_pipeValid [RD_LAT];
    logic [ADDR_W-1:0] r_pipeAddr  [RD_LAT];

    logic              w_lastAddr;
    logic              w_startPass;
    logic              w_cmpValid;
    logic [ADDR_W-1:0] w_cmpAddr;
    logic [DATA_W-1:0] w_expData;
    logic              w_mismatch;

    assign w_lastAddr = (r_cnt == LAST_ADDR);

    // The oldest stage of the read pipeline lines up with the word the RAM
    // is presenting this cycle.
    assign w_cmpValid = r_pipeValid[RD_LAT-1];
    assign w_cmpAddr  = r_pipeAddr[RD_LAT-1];
    assign w_expData  = DATA_W'(w_cmpAddr) + r_seed;
    assign w_mismatch = w_cmpValid && (ram.ram_rd_data != w_expData);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. w_startPass marks the cycle that kicks off a pass so
    // the datapath can clear the previous results at the same edge.
    always_comb begin
        w_nextState = r_state;
        w_startPass = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_startPass = 1'b1;
                    w_nextState = S_WRITE;
                end
            end
            S_WRITE: begin
                if (w_lastAddr) begin
                    w_nextState = S_READ;
                end
            end
            S_READ: begin
                if (w_lastAddr) begin
                    w_nextState = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drainCnt == DRAIN_LAST) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
`ifdef BIST_AUTO_LOOP_EN
                w_startPass = 1'b1;
                w_nextState = S_WRITE;
`else
                w_nextState = S_IDLE;
`endif
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // RAM bus and status outputs are decoded from the state so the RAM is
    // never enabled outside the write and read phases. During DONE the pass
    // flag shows the fresh result; afterwards the latched copy holds it.
    always_comb begin
        ram.ram_en      = 1'b0;
        ram.ram_we      = 1'b0;
        ram.ram_addr    = '0;
        ram.ram_wr_data = '0;
        if (r_state == S_WRITE) begin
            ram.ram_en      = 1'b1;
            ram.ram_we      = 1'b1;
            ram.ram_addr    = r_cnt;
            ram.ram_wr_data = DATA_W'(r_cnt) + r_seed;
        end else if (r_state == S_READ) begin
            ram.ram_en   = 1'b1;
            ram.ram_addr = r_cnt;
        end
        busy           = (r_state == S_WRITE) || (r_state == S_READ) || (r_state == S_DRAIN);
        done           = (r_state == S_DONE);
        pass           = (r_state == S_DONE) ? (r_errCnt == 8'd0) : r_pass;
        err_cnt        = r_errCnt;
        first_err_addr = r_firstErr;
    end

    // Address/drain counters, read pipeline, error bookkeeping and seed.
    // A reset flushes the pipeline so a half-finished pass leaves nothing
    // behind to be compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_drainCnt <= '0;
            r_seed     <= '0;
            r_errCnt   <= '0;
            r_firstErr <= '0;
            r_pass     <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipeValid[i] <= 1'b0;
                r_pipeAddr[i]  <= '0;
            end
        end else begin
            if (w_startPass) begin
                r_cnt <= '0;
            end else if ((r_state == S_WRITE) || (r_state == S_READ)) begin
                r_cnt <= w_lastAddr ? '0 : r_cnt + 1'b1;
            end

            r_drainCnt <= (r_state == S_DRAIN) ? r_drainCnt + 3'd1 : 3'd0;

            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                r_pipeAddr[i]  <= r_pipeAddr[i-1];
            end
            r_pipeValid[0] <= (r_state == S_READ);
            r_pipeAddr[0]  <= r_cnt;

            if (w_mismatch) begin
                if (r_errCnt != 8'd255) begin
                    r_errCnt <= r_errCnt + 8'd1;
                end
                if (r_errCnt == 8'd0) begin
                    r_firstErr <= w_cmpAddr;
                end
            end

            if (r_state == S_DONE) begin
                r_seed <= r_seed + 1'b1;
                r_pass <= (r_errCnt == 8'd0);
            end

            if (w_startPass) begin
                r_errCnt   <= '0;
                r_firstErr <= '0;
                r_pass     <= 1'b0;
            end
        end
    end

endmodule
